// File: rtl/nes_pad_reader_if.sv
// Host-side and pad-side signals of the NES pad reader.
//   enable        - periodic polling active
//   poll_now      - single-cycle request for an immediate poll
//   pad_data      - serial data from the pad, active-low, asynchronous
//   pad_latch     - parallel-load strobe to the pad, active-high
//   pad_clk       - shift clock to the pad, idles high
//   buttons       - last completed sample, 1 = pressed
//   buttons_valid - one-cycle pulse when buttons is updated
//   busy          - poll in progress
// master: the host/pad side. slave: the reader.
interface nes_pad_reader_if;
  logic       enable;
  logic       poll_now;
  logic       pad_data;
  logic       pad_latch;
  logic       pad_clk;
  logic [7:0] buttons;
  logic       buttons_valid;
  logic       busy;

  modport master (
    output enable, poll_now, pad_data,
    input  pad_latch, pad_clk, buttons, buttons_valid, busy
  );

  modport slave (
    input  enable, poll_now, pad_data,
    output pad_latch, pad_clk, buttons, buttons_valid, busy
  );
endinterface

// File: rtl/nes_pad_reader.sv
// Reader for a 4021-based NES controller. It pulses pad_latch, clocks the
// remaining seven buttons out with pad_clk and publishes the eight button
// states (1 = pressed) on buttons with a one-cycle buttons_valid pulse.
// Ports:
//   clk - system clock
//   rst - asynchronous, active-low reset
//   bus - nes_pad_reader_if.slave (enable, poll_now, pad_data in;
//         pad_latch, pad_clk, buttons, buttons_valid, busy out)
// Bit order of buttons: [0]=A [1]=B [2]=Select [3]=Start [4]=Up [5]=Down
// [6]=Left [7]=Right.
module nes_pad_reader #(
  parameter int unsigned HALF_PERIOD  = 300,
  parameter int unsigned LATCH_CYCLES = 600,
  parameter int unsigned POLL_CYCLES  = 833333
) (
  input logic             clk,
  input logic             rst,
  nes_pad_reader_if.slave bus
);

  localparam int unsigned PhaseMax = (HALF_PERIOD > LATCH_CYCLES) ? HALF_PERIOD : LATCH_CYCLES;
  localparam int unsigned PW       = $clog2(PhaseMax + 1);
  localparam int unsigned TW       = $clog2(POLL_CYCLES + 1);

  typedef enum logic [2:0] {StIdle, StLatch, StLgap, StClkLo, StClkHi, StDone} state_e;

  state_e          state_q;
  logic [TW-1:0]   timer_q;
  logic [PW-1:0]   phase_q;
  logic [2:0]      bit_idx_q;
  logic [6:0]      shift_q;
  logic [1:0]      sync_q;
  logic            latch_q;
  logic            pclk_q;
  logic [7:0]      buttons_q;
  logic            valid_q;
  logic            busy_q;

  logic pressed;
  logic last_half;
  logic last_latch;
  logic timer_done;

  // Pad data is active-low; a pulled-up (disconnected) line reads as released.
  assign pressed    = ~sync_q[1];
  assign last_half  = (phase_q == PW'(HALF_PERIOD - 1));
  assign last_latch = (phase_q == PW'(LATCH_CYCLES - 1));
  assign timer_done = (timer_q == TW'(POLL_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      phase_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      sync_q    <= 2'b11;
      latch_q   <= 1'b0;
      pclk_q    <= 1'b1;
      buttons_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], bus.pad_data};
      valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.poll_now || (bus.enable && timer_done)) begin
            state_q <= StLatch;
            latch_q <= 1'b1;
            busy_q  <= 1'b1;
            timer_q <= '0;
            phase_q <= '0;
          end else if (bus.enable) begin
            timer_q <= timer_q + 1'b1;
          end else begin
            timer_q <= '0;
          end
        end
        StLatch: begin
          if (last_latch) begin
            state_q <= StLgap;
            latch_q <= 1'b0;
            phase_q <= '0;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        StLgap: begin
          if (last_half) begin
            // Button A is presented by the pad as soon as it is latched.
            shift_q   <= {pressed, shift_q[6:1]};
            state_q   <= StClkLo;
            pclk_q    <= 1'b0;
            phase_q   <= '0;
            bit_idx_q <= 3'd1;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        StClkLo: begin
          if (last_half) begin
            state_q <= StClkHi;
            pclk_q  <= 1'b1;
            phase_q <= '0;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        StClkHi: begin
          if (last_half) begin
            phase_q <= '0;
            if (bit_idx_q == 3'd7) begin
              // Publish the whole byte at once so a partial sample is never seen.
              state_q   <= StDone;
              buttons_q <= {pressed, shift_q};
              valid_q   <= 1'b1;
            end else begin
              shift_q   <= {pressed, shift_q[6:1]};
              bit_idx_q <= bit_idx_q + 3'd1;
              state_q   <= StClkLo;
              pclk_q    <= 1'b0;
            end
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        StDone: begin
          state_q   <= StIdle;
          busy_q    <= 1'b0;
          bit_idx_q <= '0;
          timer_q   <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.pad_latch     = latch_q;
  assign bus.pad_clk       = pclk_q;
  assign bus.buttons       = buttons_q;
  assign bus.buttons_valid = valid_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_nes_pad_reader.sv
// Self-checking bench for nes_pad_reader with a behavioural 4021 pad model.
module tb_nes_pad_reader;
  localparam int unsigned HP       = 4;
  localparam int unsigned LC       = 8;
  localparam int unsigned PC       = 200;
  localparam int unsigned POLL_LEN = LC + 15 * HP + 1;  // 69
  localparam int unsigned PERIOD   = PC + POLL_LEN;     // 269

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nes_pad_reader_if bus ();

  nes_pad_reader #(
    .HALF_PERIOD (HP),
    .LATCH_CYCLES(LC),
    .POLL_CYCLES (PC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // 4021 model: parallel load while latch high, shift toward Q8 on pad_clk rise.
  logic [7:0] pad_mask  = 8'h00;
  logic [7:0] pad_sr    = 8'hFF;
  logic       force_en  = 1'b0;
  logic       force_val = 1'b1;
  always @(posedge bus.pad_clk or posedge bus.pad_latch) begin
    if (bus.pad_latch) pad_sr <= ~pad_mask;
    else               pad_sr <= {1'b1, pad_sr[7:1]};
  end
  assign bus.pad_data = force_en ? force_val : pad_sr[0];

  // Activity monitor, sampled on the falling edge.
  int   cyc = 0;
  int   latch_hi_n = 0, clk_fall_n = 0, busy_n = 0, valid_n = 0;
  int   latch_rise_at = 0, valid_at = 0;
  logic prev_latch = 1'b0, prev_pclk = 1'b1;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    prev_latch <= bus.pad_latch;
    prev_pclk  <= bus.pad_clk;
    if (bus.pad_latch && !prev_latch) latch_rise_at <= cyc;
    if (bus.pad_latch) latch_hi_n <= latch_hi_n + 1;
    if (!bus.pad_clk && prev_pclk) clk_fall_n <= clk_fall_n + 1;
    if (bus.busy) busy_n <= busy_n + 1;
    if (bus.buttons_valid) begin
      valid_n  <= valid_n + 1;
      valid_at <= cyc;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk);
      #1;
      if (bus.buttons_valid === 1'b1) ok = 1'b1;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pclk(input logic level, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk);
      #1;
      if (bus.pad_clk === level) ok = 1'b1;
    end
  endtask

  task automatic pulse_poll_now();
    @(negedge clk);
    bus.poll_now = 1'b1;
    @(negedge clk);
    bus.poll_now = 1'b0;
  endtask

  // One on-demand poll with full timing and shape checks.
  task automatic run_poll(input string name, input logic [7:0] exp);
    int l0, c0, b0, v0;
    bit ok;
    l0 = latch_hi_n;
    c0 = clk_fall_n;
    b0 = busy_n;
    v0 = valid_n;
    pulse_poll_now();
    wait_valid(200, ok);
    check({name, "_valid_seen"}, 32'(ok), 32'd1);
    wait_cycles(5);
    check({name, "_latch_cycles"}, latch_hi_n - l0, LC);
    check({name, "_clk_pulses"}, clk_fall_n - c0, 7);
    check({name, "_busy_cycles"}, busy_n - b0, POLL_LEN);
    check({name, "_valid_pulses"}, valid_n - v0, 1);
    check({name, "_latency"}, valid_at - latch_rise_at, LC + 15 * HP);
    check({name, "_buttons"}, 32'(bus.buttons), 32'(exp));
  endtask

  typedef struct {
    logic [7:0] mask;
    logic       force_en;
    logic       force_val;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int l0, c0, v0, b0, t0;

    vecs[0] = '{mask: 8'hA5, force_en: 1'b0, force_val: 1'b0, exp: 8'hA5};
    vecs[1] = '{mask: 8'h00, force_en: 1'b1, force_val: 1'b1, exp: 8'h00};
    vecs[2] = '{mask: 8'h00, force_en: 1'b1, force_val: 1'b0, exp: 8'hFF};
    vecs[3] = '{mask: 8'h01, force_en: 1'b0, force_val: 1'b0, exp: 8'h01};
    vecs[4] = '{mask: 8'h80, force_en: 1'b0, force_val: 1'b0, exp: 8'h80};
    vecs[5] = '{mask: 8'h5A, force_en: 1'b0, force_val: 1'b0, exp: 8'h5A};

    bus.enable   = 1'b0;
    bus.poll_now = 1'b0;

    // Reset state and quiet idle.
    #1 rst = 1'b0;
    wait_cycles(3);
    check("rst_pad_latch", 32'(bus.pad_latch), 32'd0);
    check("rst_pad_clk", 32'(bus.pad_clk), 32'd1);
    check("rst_buttons", 32'(bus.buttons), 32'h00);
    check("rst_valid", 32'(bus.buttons_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    l0 = latch_hi_n;
    c0 = clk_fall_n;
    b0 = busy_n;
    v0 = valid_n;
    wait_cycles(1000);
    check("idle_latch", latch_hi_n - l0, 0);
    check("idle_clk", clk_fall_n - c0, 0);
    check("idle_busy", busy_n - b0, 0);
    check("idle_valid", valid_n - v0, 0);

    // Directed pad patterns.
    for (int i = 0; i < 6; i++) begin
      pad_mask  = vecs[i].mask;
      force_en  = vecs[i].force_en;
      force_val = vecs[i].force_val;
      run_poll($sformatf("vec%0d", i), vecs[i].exp);
    end
    force_en = 1'b0;

    // Periodic polling.
    pad_mask = 8'h3C;
    @(negedge clk);
    bus.enable = 1'b1;
    wait_valid(PERIOD + 20, ok);
    check("per_first_seen", 32'(ok), 32'd1);
    check("per_first_buttons", 32'(bus.buttons), 32'h3C);
    t0 = valid_at;
    wait_valid(PERIOD + 20, ok);
    check("per_second_seen", 32'(ok), 32'd1);
    check("per_spacing1", valid_at - t0, PERIOD);
    check("per_second_buttons", 32'(bus.buttons), 32'h3C);
    pad_mask = 8'h81;
    t0 = valid_at;
    wait_valid(PERIOD + 20, ok);
    check("per_third_seen", 32'(ok), 32'd1);
    check("per_spacing2", valid_at - t0, PERIOD);
    check("per_third_buttons", 32'(bus.buttons), 32'h81);
    bus.enable = 1'b0;
    v0 = valid_n;
    wait_cycles(500);
    check("per_stopped", valid_n - v0, 0);

    // Re-pulsed poll_now during CLK_HI and enable dropped mid-poll.
    pad_mask = 8'h66;
    l0 = latch_hi_n;
    c0 = clk_fall_n;
    v0 = valid_n;
    @(negedge clk);
    bus.enable   = 1'b1;
    bus.poll_now = 1'b1;
    @(negedge clk);
    bus.poll_now = 1'b0;
    wait_pclk(1'b0, 100, ok);
    check("mid_clk_low_seen", 32'(ok), 32'd1);
    wait_pclk(1'b1, 100, ok);
    check("mid_clk_high_seen", 32'(ok), 32'd1);
    pulse_poll_now();
    bus.enable = 1'b0;
    wait_cycles(600);
    check("mid_valid_pulses", valid_n - v0, 1);
    check("mid_latch_cycles", latch_hi_n - l0, LC);
    check("mid_clk_pulses", clk_fall_n - c0, 7);
    check("mid_buttons", 32'(bus.buttons), 32'h66);

    // Reset during CLK_LO of bit 3.
    pad_mask = 8'h5A;
    run_poll("pre_rst", 8'h5A);
    pad_mask = 8'hF0;
    pulse_poll_now();
    for (int k = 0; k < 3; k++) begin
      wait_pclk(1'b0, 100, ok);
      check($sformatf("rst_mid_fall%0d", k + 1), 32'(ok), 32'd1);
      if (k < 2) wait_pclk(1'b1, 100, ok);
    end
    v0 = valid_n;
    #2 rst = 1'b0;
    #1;
    check("rst_mid_pad_clk", 32'(bus.pad_clk), 32'd1);
    check("rst_mid_pad_latch", 32'(bus.pad_latch), 32'd0);
    check("rst_mid_buttons", 32'(bus.buttons), 32'h00);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    wait_cycles(3);
    @(negedge clk);
    rst = 1'b1;
    wait_cycles(300);
    check("rst_mid_no_valid", valid_n - v0, 0);
    check("rst_mid_buttons_held", 32'(bus.buttons), 32'h00);
    pad_mask = 8'hC3;
    run_poll("post_rst", 8'hC3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/nes_pad_reader.md
Name: nes_pad_reader

Overview:
- Host-side reader for a physical NES controller, a 4021-style parallel-in/serial-out shift register.
- Drives the pad's LATCH and CLK lines and samples its serial DATA line.
- Assembles the eight button states into a parallel byte, active-high.
- The byte feeds the joypad register emulator's joycon_ctrl_input. Polling runs periodically, or on demand with poll_now.

Parameters:
HALF_PERIOD, 300, clk cycles per pad_clk half-period; minimum 4 (6 us at 50 MHz)
LATCH_CYCLES, 600, clk cycles pad_latch is held high; minimum 1 (12 us at 50 MHz)
POLL_CYCLES, 833333, clk cycles spent in IDLE between periodic polls; minimum 2 (~60 Hz)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
enable  input  1  1 = periodic polling active
poll_now  input  1  single-cycle request for an immediate poll
pad_data  input  1  serial data from pad, active-low (0 = pressed); asynchronous
pad_latch  output  1  parallel-load strobe to pad, active-high
pad_clk  output  1  shift clock to pad; idles high, pad shifts on rising edge
buttons  output  8  last completed sample, 1 = pressed; bit order [0]=A,[1]=B,[2]=Select,[3]=Start,[4]=Up,[5]=Down,[6]=Left,[7]=Right
buttons_valid  output  1  one-cycle pulse when buttons is updated
busy  output  1  1 while a poll is in progress (any state other than IDLE)

Behaviour:
- Reset values, applied asynchronously and immediately: pad_latch=0, pad_clk=1, buttons=8'h00, buttons_valid=0, busy=0, FSM=IDLE, poll timer=0, phase counter=0, bit index=0, synchronizer flops=1.
- pad_data passes through a 2-FF synchronizer. All sampling uses the synchronized value.
- All outputs are registered.
- IDLE:
  - Poll timer increments every cycle while enable=1.
  - The timer holds at 0 when enable=0.
  - A poll starts in the next cycle if poll_now=1, or if enable=1 and timer==POLL_CYCLES-1.
  - Starting a poll clears the timer. Simultaneous poll_now and timer expiry start one poll.
- LATCH: pad_latch=1 for LATCH_CYCLES cycles, then go to LGAP.
- LGAP:
  - pad_latch=0, pad_clk=1, for HALF_PERIOD cycles.
  - In the last cycle, capture the inverted synchronized data into shift bit 0.
- CLK_LO: pad_clk=0 for HALF_PERIOD cycles.
- CLK_HI:
  - pad_clk=1 for HALF_PERIOD cycles.
  - In the last cycle, capture the inverted synchronized data into shift bit n (n=1..7).
  - If n<7, go to CLK_LO with n+1. If n=7, go to DONE.
- Clock pulse count: exactly 7 pad_clk low pulses per poll. No trailing clock.
- DONE (1 cycle):
  - buttons <= shift register; buttons_valid=1; busy=1.
  - Return to IDLE; the timer restarts from 0.
- Timing:
  - Poll length, first pad_latch-high cycle through the DONE cycle inclusive: LATCH_CYCLES + 15*HALF_PERIOD + 1 cycles.
  - buttons_valid asserts LATCH_CYCLES + 15*HALF_PERIOD cycles after the first pad_latch-high cycle.
  - Periodic spacing between buttons_valid pulses with enable held high: POLL_CYCLES + LATCH_CYCLES + 15*HALF_PERIOD + 1 cycles.
- poll_now while busy=1 is ignored; it is not queued.
- enable deasserted mid-poll: the current poll completes normally.
- buttons holds its value between polls. The shift register is never visible partially filled.
- Disconnected pad: the line is pulled high by the board, so buttons reads 8'h00. No fault detection.
- Reset mid-poll: all outputs return to reset values at once. No buttons_valid is produced for the aborted poll.

Test Plan:
Common bench setup: HALF_PERIOD=4, LATCH_CYCLES=8, POLL_CYCLES=200, with a behavioural 4021 pad model. The model loads on pad_latch high, shifts on pad_clk rising edge, and drives active-low data.
1. Reset check -> with rst=0: pad_latch=0, pad_clk=1, buttons=00, buttons_valid=0, busy=0. After release with enable=0, poll_now=0: no activity for 1000 cycles.
2. poll_now pulse, pad pressed mask 8'hA5 -> pad_latch high for 8 cycles, then exactly 7 pad_clk low pulses of 4 cycles each. buttons=8'hA5 with a single buttons_valid pulse 68 cycles after the first latch-high cycle. busy high for 69 cycles.
3. enable=1, pad mask 8'h3C -> buttons_valid pulses spaced exactly 269 cycles apart, buttons=8'h3C each time. Change the mask to 8'h81 -> the next pulse reports 8'h81.
4. pad_data held 1 -> buttons=8'h00. pad_data held 0 -> buttons=8'hFF. Single-button masks 8'h01 and 8'h80 -> correct bit ordering.
5. poll_now re-pulsed during CLK_HI; enable dropped mid-poll -> the current poll completes once. No second poll starts, and there is no periodic restart afterwards.
6. rst asserted during CLK_LO of bit 3, prior buttons=8'h5A -> pad_clk=1, pad_latch=0, buttons=00 immediately. No buttons_valid follows. After release, a poll_now gives a correct full poll.
